// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : 8-way round-robin arbiter with registered one-hot grant and a
//            hold-time limit that forces release and flags a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic       r_timeout;

    logic       w_load;
    logic       w_release;
    logic       w_timeout_next;
    logic       w_done_rel;
    logic       w_drop_rel;
    logic       w_hold_rel;
    logic [2:0] w_win_idx;

    // First set request scanning upward from ptr, wrapping 7 -> 0.
    function automatic logic [2:0] f_pick(input logic [7:0] req_v, input logic [2:0] ptr_v);
        logic [2:0] v_idx;
        logic       v_found;
        f_pick  = ptr_v;
        v_found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            v_idx = ptr_v + 3'(k);
            if (!v_found && req_v[v_idx]) begin
                f_pick  = v_idx;
                v_found = 1'b1;
            end
        end
    endfunction

    assign w_win_idx  = f_pick(req, r_ptr);
    assign w_done_rel = done;
    assign w_drop_rel = ~req[r_gnt_idx];
    assign w_hold_rel = (r_hold_cnt == c_hold_last);

    always_comb begin
        w_state_next   = r_state;
        w_load         = 1'b0;
        w_release      = 1'b0;
        w_timeout_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 8'h00) begin
                    w_state_next = ST_GRANT;
                    w_load       = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_done_rel || w_drop_rel || w_hold_rel) begin
                    w_state_next   = ST_IDLE;
                    w_release      = 1'b1;
                    // Timeout only when the hold limit is the sole cause.
                    w_timeout_next = w_hold_rel && !w_done_rel && !w_drop_rel;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timeout <= w_timeout_next;
            if (w_load) begin
                r_gnt       <= 8'(1) << w_win_idx;
                r_gnt_idx   <= w_win_idx;
                r_gnt_valid <= 1'b1;
                r_hold_cnt  <= 8'd0;
            end else if (w_release) begin
                r_gnt       <= 8'h00;
                r_gnt_idx   <= 3'd0;
                r_gnt_valid <= 1'b0;
                r_hold_cnt  <= 8'd0;
                r_ptr       <= r_gnt_idx + 3'd1;
            end else if (r_state == ST_GRANT) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have one parameter line: MAX_HOLD, default 16, the maximum number of cycles a grant is held before forced release (legal range 2..255).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 The ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  8  request lines, bit i = requester i
- done  input  1  current owner releases the resource
- gnt  output  8  one-hot grant, registered
- gnt_idx  output  3  binary index of the granted requester (8-to-3 encoded gnt), registered
- gnt_valid  output  1  high while any grant is active, registered
- timeout  output  1  one-cycle pulse on forced release, registered

Function
REQ-004 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-005 In IDLE, gnt SHALL be 8'h00, gnt_idx 3'd0, gnt_valid 0.
REQ-006 In IDLE with req != 0 at a rising edge, the FSM SHALL enter GRANT at that edge and select the winner.
- Winner = first set req bit scanning from ptr upward: ptr, ptr+1, ... 7, 0, ..., ptr-1.
- Latency from req sampled to gnt visible SHALL be 1 cycle.
REQ-007 In IDLE, done SHALL be ignored.
REQ-008 In GRANT, gnt, gnt_idx and gnt_valid SHALL be held stable until release, regardless of other req changes.
REQ-009 gnt SHALL always be one-hot or zero, and gnt_idx SHALL always equal the encoded position of the set gnt bit.
REQ-010 In GRANT, hold_cnt (8-bit, cleared on grant entry) SHALL increment every cycle.
REQ-011 Release SHALL occur at the first rising edge in GRANT where any of the following is true:
- done = 1
- req[gnt_idx] = 0
- hold_cnt = MAX_HOLD-1
So a grant is visible for at most MAX_HOLD cycles.
REQ-012 On release, the following SHALL happen:
- FSM returns to IDLE.
- gnt, gnt_idx and gnt_valid clear at that edge.
- ptr <= gnt_idx+1, with 7 wrapping to 0.
- hold_cnt <= 0.
REQ-013 After every release there SHALL be exactly one IDLE cycle before the next grant; back-to-back grants are not allowed.
REQ-014 timeout SHALL pulse high for exactly one cycle, coincident with the first IDLE cycle, only when the release was caused solely by hold_cnt.
REQ-015 If done or the req drop coincides with the hold limit, timeout SHALL stay 0.
REQ-016 ptr (3-bit) SHALL change only on release.

Reset
REQ-017 At a rising edge with rst_n = 0, the block SHALL set:
- state = IDLE, ptr = 0, hold_cnt = 0
- gnt = 8'h00, gnt_idx = 3'd0, gnt_valid = 0, timeout = 0
REQ-018 Reset asserted during GRANT SHALL drop the grant at that same edge, with no timeout pulse and no ptr advance beyond 0.
REQ-019 The first arbitration after reset release SHALL use ptr = 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single request: reset, then req = 8'h08 → one cycle later gnt = 8'h08, gnt_idx = 3, gnt_valid = 1. Pulse done → next cycle gnt = 0. Then req = 8'h18 → grant goes to index 4 (ptr = 4).
- Full fairness: req = 8'hFF held, done pulsed on each grant's first cycle → gnt_idx sequence 0,1,2,3,4,5,6,7,0, with one IDLE cycle between grants.
- Timeout: MAX_HOLD = 16, req = 8'h20 held, done = 0 → gnt = 8'h20 for exactly 16 cycles, then timeout = 1 for one cycle. Regrant to index 5 after one IDLE cycle.
- Wrap-around: ptr = 7 (after granting 6), req = 8'h41 → gnt_idx = 0, not 6.
- Timeout/done collision: done = 1 on the edge where hold_cnt = MAX_HOLD-1 → release occurs and timeout stays 0.
- Reset mid-grant: grant active on index 3, rst_n = 0 for one cycle → gnt = 0 at that edge. Then req = 8'h82 → gnt_idx = 1.
